// File: rtl/matrix_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_mul_seq: sequential signed fixed-point matrix multiply, one MAC.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module matrix_mul_seq #(
   parameter int M     = 4,
   parameter int K     = 4,
   parameter int N     = 4,
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int ACC_W = 2*WIDTH + $clog2(K) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [M*K*WIDTH-1:0]     matA,
   input  logic [K*N*WIDTH-1:0]     matB,
   input  logic                     imagA,
   input  logic                     imagB,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [M*N*WIDTH-1:0]     res,
   output logic                     sat
);

   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam int JW = (N > 1) ? $clog2(N) : 1;
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   localparam logic signed [ACC_W-1:0] c_max = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_min = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [M-1:0][K-1:0][WIDTH-1:0] r_a;
   logic [K-1:0][N-1:0][WIDTH-1:0] r_b;
   logic [M-1:0][N-1:0][WIDTH-1:0] r_res;
   logic                           r_neg;
   logic                           r_sat;
   logic [IW-1:0]                  r_i;
   logic [JW-1:0]                  r_j;
   logic [KW-1:0]                  r_k;
   logic signed [ACC_W-1:0]        r_acc;

   logic                           w_accept;
   logic                           w_last_i;
   logic                           w_last_j;
   logic                           w_last_k;
   logic signed [2*WIDTH-1:0]      w_prod;
   logic signed [ACC_W-1:0]        w_term;
   logic signed [ACC_W-1:0]        w_acc_final;
   logic signed [ACC_W-1:0]        w_scaled;
   logic [WIDTH-1:0]               w_elem;
   logic                           w_clamp;

   assign w_accept = in_valid && in_ready;
   assign w_last_i = (r_i == IW'(M-1));
   assign w_last_j = (r_j == JW'(N-1));
   assign w_last_k = (r_k == KW'(K-1));

   assign w_prod      = $signed(r_a[r_i][r_k]) * $signed(r_b[r_k][r_j]);
   assign w_term      = ACC_W'(w_prod);
   assign w_acc_final = r_acc + (r_neg ? -w_term : w_term);
   // Arithmetic shift floors toward -inf; no rounding is applied.
   assign w_scaled    = w_acc_final >>> FRAC;

   always_comb begin
      w_elem  = w_scaled[WIDTH-1:0];
      w_clamp = 1'b0;
      if (w_scaled > c_max) begin
         w_elem  = c_max[WIDTH-1:0];
         w_clamp = 1'b1;
      end else if (w_scaled < c_min) begin
         w_elem  = c_min[WIDTH-1:0];
         w_clamp = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = rst_n;
            if (w_accept) w_state_next = CALC;
         end
         CALC: begin
            if (w_last_k && w_last_j && w_last_i) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_res <= '0;
         r_neg <= 1'b0;
         r_sat <= 1'b0;
         r_i   <= '0;
         r_j   <= '0;
         r_k   <= '0;
         r_acc <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a   <= matA;
                  r_b   <= matB;
                  r_neg <= imagA && imagB;
                  r_sat <= 1'b0;
                  r_i   <= '0;
                  r_j   <= '0;
                  r_k   <= '0;
                  r_acc <= '0;
               end
            end
            CALC: begin
               if (w_last_k) begin
                  r_res[r_i][r_j] <= w_elem;
                  r_sat           <= r_sat | w_clamp;
                  r_acc           <= '0;
                  r_k             <= '0;
                  if (w_last_j) begin
                     r_j <= '0;
                     r_i <= w_last_i ? '0 : r_i + 1'b1;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end else begin
                  r_acc <= w_acc_final;
                  r_k   <= r_k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign res = r_res;
   assign sat = r_sat;

endmodule
`default_nettype wire
